serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Parametrised bit-serial N-bit subtractor with borrow-in. It is the sequential successor to the single-bit half/full subtractor cells: one subtractor bit-slice plus a borrow flip-flop processes operands LSB-first, one bit per clock. A start/busy/done handshake lets a controller launch operations and collect results. It targets area-constrained datapaths where a WIDTH-cycle latency is acceptable.

Parameters:
WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a new operation; sampled only while idle.
a  input  WIDTH  minuend; sampled on the edge that accepts start.
b  input  WIDTH  subtrahend; sampled on the edge that accepts start.
bin  input  1  borrow-in; sampled on the edge that accepts start.
busy  output  1  high while an operation is in progress.
done  output  1  single-cycle pulse when diff/borrow become valid.
diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
borrow  output  1  final borrow-out; 1 when a < b + bin, unsigned.

Behaviour:
- Clocking/reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, busy=0, done=0, diff=0, borrow=0, bit counter=0, internal shift and borrow registers=0.
- FSM states: IDLE and RUN.
- IDLE, start=1 at edge k:
  - latch a and b into shift registers A_sh and B_sh;
  - latch bin into borrow register br;
  - clear the counter;
  - go to RUN; busy=1 from edge k.
- IDLE, start=0: hold all outputs.
- RUN, each edge processes bit i = A_sh[0], B_sh[0]:
  - d = A_sh[0] ^ B_sh[0] ^ br
  - br_next = (~A_sh[0] & B_sh[0]) | (~(A_sh[0] ^ B_sh[0]) & br)
  - shift d into the MSB of internal result register R (R shifts right);
  - shift A_sh and B_sh right by one;
  - increment the counter. Counter width is $clog2(WIDTH+1).
- Completion is the edge where the counter reaches WIDTH-1 in RUN, i.e. edge k+WIDTH:
  - diff <= completed R; borrow <= br_next;
  - done <= 1 for exactly one cycle; busy <= 0; state <= IDLE.
- Latency: done is high in the cycle after edge k+WIDTH. WIDTH=1 gives a one-edge operation.
- Output hold: diff and borrow change only at completion or reset, never mid-operation. They hold until the next completion.
- start while busy=1: ignored. Operands are not re-sampled and no error is flagged.
- Back-to-back: start=1 in the cycle where done=1 is accepted, since state is IDLE. The next done follows WIDTH edges later.
- rst=1 mid-operation: aborts immediately. All registers return to reset values; no done pulse.
- rst and start both high: rst wins.
- Arithmetic: unsigned modulo 2^WIDTH. {borrow, diff} equals the (WIDTH+1)-bit two's complement of a - b - bin.

Optional Feature:
SERIAL_SUB_SIGNED_OVF_EN
- Defined: adds output port ovf (1 bit, reset 0), updated with diff at completion.
  - Value: ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ diff[WIDTH-1]), using the sampled a and b.
  - This flags two's-complement signed overflow; ovf holds like diff.
  - Requires the MSBs of a and b to be kept in a register at start.
- Undefined: ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, bin=0, start pulse -> busy high 8 cycles, done pulse 8 edges after acceptance, diff=0x1E, borrow=0.
2. WIDTH=8, a=0x00, b=0x01, bin=0 -> diff=0xFF, borrow=1. Then a=0x10, b=0x0F, bin=1 issued back-to-back in the done cycle -> diff=0x00, borrow=0, done 8 edges later.
3. WIDTH=8 with SERIAL_SUB_SIGNED_OVF_EN defined: a=0x80, b=0x01, bin=0 -> diff=0x7F, borrow=0, ovf=1. Then a=0x05, b=0x03 -> diff=0x02, ovf=0.
4. Start 0x5A-0x3C, then pulse start with a=0xFF, b=0x00 at cycle 3 of RUN -> second start ignored, result still 0x1E, single done pulse.
5. Start an operation and assert rst at cycle 4 of RUN -> next cycle busy=0, done=0, diff=0x00, borrow=0, and no done pulse afterward. Then a fresh operation completes correctly.
6. WIDTH=1, all 8 combinations of a, b, bin -> {borrow, diff} matches the full-subtractor truth table, e.g. a=1, b=1, bin=0 -> diff=0, borrow=0; a=0, b=0, bin=1 -> diff=1, borrow=1; done one edge after start.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, computing diff = a - b - bin over WIDTH clocks.
// Optional macro SERIAL_SUB_SIGNED_OVF_EN adds a registered signed-overflow output ovf.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUB_SIGNED_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_a_sh, w_a_sh_nxt;
   logic [WIDTH-1:0] r_b_sh, w_b_sh_nxt;
   logic [WIDTH-1:0] r_res, w_res_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic             r_br, w_br_nxt;
   logic             w_busy_nxt, w_done_nxt, w_borrow_nxt;
   logic [WIDTH-1:0] w_diff_nxt;

   logic             w_d;
   logic             w_br_bit;
   logic [WIDTH-1:0] w_res_shift;
   logic             w_last;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
   logic r_a_msb, w_a_msb_nxt;
   logic r_b_msb, w_b_msb_nxt;
   logic w_ovf_nxt;
`endif

   // One full-subtractor bit-slice on the current LSBs plus the borrow flop.
   always_comb begin
      w_d         = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
      w_br_bit    = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_br);
      w_res_shift = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
      w_last      = (r_cnt == CW'(WIDTH - 1));
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_a_sh_nxt   = r_a_sh;
      w_b_sh_nxt   = r_b_sh;
      w_res_nxt    = r_res;
      w_cnt_nxt    = r_cnt;
      w_br_nxt     = r_br;
      w_busy_nxt   = busy;
      w_done_nxt   = 1'b0;
      w_diff_nxt   = diff;
      w_borrow_nxt = borrow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      w_a_msb_nxt  = r_a_msb;
      w_b_msb_nxt  = r_b_msb;
      w_ovf_nxt    = ovf;
`endif
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_a_sh_nxt  = a;
               w_b_sh_nxt  = b;
               w_br_nxt    = bin;
               w_res_nxt   = '0;
               w_cnt_nxt   = '0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_RUN;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
               w_a_msb_nxt = a[WIDTH-1];
               w_b_msb_nxt = b[WIDTH-1];
`endif
            end
         end
         S_RUN: begin
            w_a_sh_nxt = r_a_sh >> 1;
            w_b_sh_nxt = r_b_sh >> 1;
            w_br_nxt   = w_br_bit;
            w_res_nxt  = w_res_shift;
            w_cnt_nxt  = r_cnt + CW'(1);
            if (w_last) begin
               w_diff_nxt   = w_res_shift;
               w_borrow_nxt = w_br_bit;
               w_done_nxt   = 1'b1;
               w_busy_nxt   = 1'b0;
               w_state_nxt  = S_IDLE;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
               w_ovf_nxt    = (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_res_shift[WIDTH-1]);
`endif
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_br    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         diff    <= '0;
         borrow  <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         ovf     <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_a_sh  <= w_a_sh_nxt;
         r_b_sh  <= w_b_sh_nxt;
         r_res   <= w_res_nxt;
         r_cnt   <= w_cnt_nxt;
         r_br    <= w_br_nxt;
         busy    <= w_busy_nxt;
         done    <= w_done_nxt;
         diff    <= w_diff_nxt;
         borrow  <= w_borrow_nxt;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
         r_a_msb <= w_a_msb_nxt;
         r_b_msb <= w_b_msb_nxt;
         ovf     <= w_ovf_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances),
// compared against a plain-arithmetic reference of a - b - bin.
module tb_serial_subtractor;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] a, b;
   logic       bin;
   logic       busy, done, borrow;
   logic [7:0] diff;

   logic       s1_start, s1_a, s1_b, s1_bin;
   logic       s1_busy, s1_done, s1_borrow;
   logic [0:0] s1_diff;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
   logic       ovf, s1_ovf;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Held results as the model expects them, plus the result of the operation in flight.
   logic [7:0] exp_diff;
   logic       exp_borrow, exp_ovf;
   logic [7:0] p_diff;
   logic       p_borrow, p_ovf;

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      , .ovf(ovf)
`endif
   );

   serial_subtractor #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(s1_start), .a(s1_a), .b(s1_b), .bin(s1_bin),
      .busy(s1_busy), .done(s1_done), .diff(s1_diff), .borrow(s1_borrow)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      , .ovf(s1_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Issue start for one cycle; returns one step after the accepting edge.
   task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic biv);
      logic [8:0] full;
      a     = av;
      b     = bv;
      bin   = biv;
      start = 1'b1;
      full  = 9'(av) - 9'(bv) - 9'(biv);
      p_diff   = full[7:0];
      p_borrow = full[8];
      p_ovf    = (av[7] ^ bv[7]) & (av[7] ^ full[7]);
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_accept", 32'(busy), 32'd1);
      check("done_accept", 32'(done), 32'd0);
   endtask

   // Wait for done (bounded), optionally re-pulsing start mid-run, then check results.
   task automatic wait_done(input int inject_at);
      int  n;
      bit  got;
      n   = 0;
      got = 1'b0;
      while (n < 20 && !got) begin
         if (n == inject_at) begin
            a     = 8'hFF;
            b     = 8'h00;
            start = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         n++;
         if (done) got = 1'b1;
         else if (n == 4) begin
            check("busy_mid", 32'(busy), 32'd1);
            check("diff_hold", 32'(diff), 32'(exp_diff));
            check("borrow_hold", 32'(borrow), 32'(exp_borrow));
         end
      end
      check("latency", 32'(n), 32'd8);
      exp_diff   = p_diff;
      exp_borrow = p_borrow;
      exp_ovf    = p_ovf;
      check("diff", 32'(diff), 32'(exp_diff));
      check("borrow", 32'(borrow), 32'(exp_borrow));
      check("busy_done", 32'(busy), 32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      check("ovf", 32'(ovf), 32'(exp_ovf));
`endif
   endtask

   // Idle cycles: no done pulse, outputs held.
   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         check("idle_done", 32'(done), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_diff", 32'({borrow, diff}), 32'({exp_borrow, exp_diff}));
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55; bin = 1'b1;
      s1_start = 1'b0; s1_a = 1'b0; s1_b = 1'b0; s1_bin = 1'b0;
      exp_diff = '0; exp_borrow = 1'b0; exp_ovf = 1'b0;
      p_diff = '0; p_borrow = 1'b0; p_ovf = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'({borrow, diff}), 32'd0);
      rst = 1'b0; start = 1'b0;
      idle(2);

      // Directed cases
      launch(8'h5A, 8'h3C, 1'b0);  wait_done(-1);
      idle(1);
      launch(8'h00, 8'h01, 1'b0);  wait_done(-1);
      launch(8'h10, 8'h0F, 1'b1);  wait_done(-1);
      idle(1);
      launch(8'h80, 8'h01, 1'b0);  wait_done(-1);
      idle(1);
      launch(8'h05, 8'h03, 1'b0);  wait_done(-1);
      idle(1);
      launch(8'h5A, 8'h3C, 1'b0);  wait_done(2);
      idle(3);

      // Abort mid-run, then a fresh operation
      launch(8'hC3, 8'h17, 1'b1);
      repeat (3) @(posedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_diff = '0; exp_borrow = 1'b0; exp_ovf = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_diff", 32'({borrow, diff}), 32'd0);
      idle(12);
      launch(8'h3E, 8'h7F, 1'b0);  wait_done(-1);
      idle(1);

      // Random operations, mixing back-to-back and gapped launches
      for (int i = 0; i < 40; i++) begin
         launch(8'($urandom), 8'($urandom), 1'($urandom));
         wait_done(-1);
         if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 3)));
      end

      // WIDTH=1: full-subtractor truth table, one-edge operation
      for (int c = 0; c < 8; c++) begin
         logic [2:0] cv;
         logic [1:0] r1;
         cv = 3'(c);
         s1_a = cv[2]; s1_b = cv[1]; s1_bin = cv[0];
         r1 = 2'(cv[2]) - 2'(cv[1]) - 2'(cv[0]);
         s1_start = 1'b1;
         @(posedge clk); #1;
         s1_start = 1'b0;
         check("w1_busy", 32'(s1_busy), 32'd1);
         @(posedge clk); #1;
         check("w1_done", 32'(s1_done), 32'd1);
         check("w1_result", 32'({s1_borrow, s1_diff}), 32'(r1));
         @(posedge clk); #1;
         check("w1_pulse", 32'(s1_done), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
